dca_matrix_load2mreg: RTL and testbench



---
 rtl/dca_matrix_load2mreg_pkg.sv | 27 ++
 rtl/dca_matrix_load2mreg_if.sv | 38 +++
 rtl/dca_row_counter_onehot.sv | 31 +++
 rtl/dca_matrix_load2mreg.sv | 122 ++++++++++++
 tb/tb_dca_matrix_load2mreg.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dca_matrix_load2mreg_pkg.sv
// Shared types and geometry for the load-to-mreg path.
// Build option DCA_LOAD2MREG_OVERFLOW_CHECK_EN adds a sticky overflow flag on the top.
package dca_matrix_pkg;

    localparam int MATRIX_SIZE_PARA = 4;
    localparam int BW_TENSOR_SCALAR = 32;
    localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA;
    localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA;
    localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } load_state_e;

    typedef logic [BW_TENSOR_ROW-1:0] tensor_row_t;

    typedef struct packed {
        load_state_e               state;
        logic [MATRIX_NUM_ROW-1:0] row;
        logic                      row_first;
        logic                      row_last;
    } load2mreg_dbg_t;

endpackage

// File: rtl/dca_matrix_load2mreg_if.sv
// Request, tensor-row stream and mreg row-move write port of the load path.
interface dca_matrix_load2mreg_if;
    import dca_matrix_pkg::*;

    // Tensor rows move on a cycle where wvalid & wready are both high; wvalid and
    // wlast/wdata are owned by the source, wready never depends on wvalid.
    logic        loadreg_wready;
    logic        loadreg_wrequest;
    logic        mreg_move_wenable;
    tensor_row_t mreg_move_wdata_list1d;
    logic        load_tensor_row_wvalid;
    logic        load_tensor_row_wlast;
    logic        load_tensor_row_wready;
    tensor_row_t load_tensor_row_wdata;

    modport slave (
        output loadreg_wready,
        input  loadreg_wrequest,
        output mreg_move_wenable,
        output mreg_move_wdata_list1d,
        input  load_tensor_row_wvalid,
        input  load_tensor_row_wlast,
        output load_tensor_row_wready,
        input  load_tensor_row_wdata
    );

    modport master (
        input  loadreg_wready,
        output loadreg_wrequest,
        input  mreg_move_wenable,
        input  mreg_move_wdata_list1d,
        output load_tensor_row_wvalid,
        output load_tensor_row_wlast,
        input  load_tensor_row_wready,
        output load_tensor_row_wdata
    );

endinterface

// File: rtl/dca_row_counter_onehot.sv
// One-hot row pointer: bit0 after reset/init, rotates left on each enabled count.
module dca_row_counter_onehot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             count,
    input  logic             enable,
    output logic [WIDTH-1:0] value,
    output logic             is_first,
    output logic             is_last
);

    localparam logic [WIDTH-1:0] FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            value_q <= FIRST;
        end else if (enable && count) begin
            value_q <= {value_q[WIDTH-2:0], value_q[WIDTH-1]};
        end
    end

    assign value    = value_q;
    assign is_first = value_q[0];
    assign is_last  = value_q[WIDTH-1];

endmodule

// File: rtl/dca_matrix_load2mreg.sv
// Streams one matrix of tensor rows into the mreg: zero-pads short streams, drains long ones.
// Build option DCA_LOAD2MREG_OVERFLOW_CHECK_EN adds the sticky overflow output.
module dca_matrix_load2mreg
    import dca_matrix_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    output logic                    busy,
`ifdef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
    output logic                    overflow,
`endif
    output load2mreg_dbg_t          dbg,
    dca_matrix_load2mreg_if.slave   bus
);

    load_state_e               state_q;
    logic                      busy_q;
    logic                      ldready_q;
    logic                      go;
    logic                      row_ready;
    logic                      acc;
    logic                      wen;
    logic                      cnt_init;
    logic [MATRIX_NUM_ROW-1:0] row_value;
    logic                      row_first;
    logic                      last_row;

    // A clear or reset cycle behaves like a stalled cycle so nothing is written while aborting.
    always_comb begin
        go        = enable && !clear && !rst;
        row_ready = go && ((state_q == LOAD) || (state_q == DRAIN));
        acc       = bus.load_tensor_row_wvalid && row_ready;
        wen       = ((state_q == LOAD) && acc) || ((state_q == FILL) && go);
        cnt_init  = clear || (state_q == IDLE);
    end

    dca_row_counter_onehot #(
        .WIDTH (MATRIX_NUM_ROW)
    ) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .init     (cnt_init),
        .count    (wen),
        .enable   (go),
        .value    (row_value),
        .is_first (row_first),
        .is_last  (last_row)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            ldready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && bus.loadreg_wrequest) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        ldready_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        if (bus.load_tensor_row_wlast && last_row) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            ldready_q <= 1'b1;
                        end else if (bus.load_tensor_row_wlast) begin
                            state_q <= FILL;
                        end else if (last_row) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                FILL: begin
                    if (go && last_row) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        ldready_q <= 1'b1;
                    end
                end
                default: begin
                    if (acc && bus.load_tensor_row_wlast) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        ldready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow_q <= 1'b0;
        end else if ((state_q == LOAD) && acc && !bus.load_tensor_row_wlast && last_row) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

    assign busy                       = busy_q;
    assign bus.loadreg_wready         = ldready_q;
    assign bus.load_tensor_row_wready = row_ready;
    assign bus.mreg_move_wenable      = wen;
    assign bus.mreg_move_wdata_list1d = (state_q == LOAD) ? bus.load_tensor_row_wdata : '0;

    assign dbg.state     = state_q;
    assign dbg.row       = row_value;
    assign dbg.row_first = row_first;
    assign dbg.row_last  = last_row;

endmodule

// File: tb/tb_dca_matrix_load2mreg.sv
// Directed bench for dca_matrix_load2mreg with a count-based reference model.
// Define DCA_LOAD2MREG_OVERFLOW_CHECK_EN to also check the overflow flag.
module tb_dca_matrix_load2mreg;
    import dca_matrix_pkg::*;

    localparam int N = MATRIX_NUM_ROW;

    logic           clk;
    logic           rst;
    logic           clear;
    logic           enable;
    logic           busy;
    logic           overflow;
    load2mreg_dbg_t dbg;

    dca_matrix_load2mreg_if bus ();

    dca_matrix_load2mreg dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enable   (enable),
        .busy     (busy),
`ifdef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
        .overflow (overflow),
`endif
        .dbg      (dbg),
        .bus      (bus)
    );

`ifndef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
    assign overflow = 1'b0;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 0;
    tensor_row_t got_q[$];
    tensor_row_t exp_q[$];

    task automatic chk(input string name, input tensor_row_t act, input tensor_row_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: rows written so far, whether the stream has ended, busy
    bit m_busy = 0;
    bit m_done = 0;
    bit m_ovf  = 0;
    int m_rows = 0;

    always @(posedge clk) begin
        if (rst || clear) begin
            m_busy = 0; m_done = 0; m_rows = 0; m_ovf = 0;
        end else if (!m_busy) begin
            if (enable && bus.loadreg_wrequest) begin
                m_busy = 1; m_done = 0; m_rows = 0;
            end
        end else if (enable) begin
            if (!m_done && m_rows < N) begin
                if (bus.load_tensor_row_wvalid) begin
                    m_rows++;
                    if (bus.load_tensor_row_wlast) m_done = 1;
                    if (m_rows == N) begin
                        if (m_done) m_busy = 0;
                        else        m_ovf  = 1;
                    end
                end
            end else if (m_done) begin
                m_rows++;
                if (m_rows == N) m_busy = 0;
            end else if (bus.load_tensor_row_wvalid && bus.load_tensor_row_wlast) begin
                m_busy = 0;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit          g, in_load, in_fill, in_drain, e_rdy, e_wen;
            tensor_row_t e_data;
            g        = enable && !clear;
            in_load  = m_busy && !m_done && (m_rows < N);
            in_fill  = m_busy && m_done;
            in_drain = m_busy && !m_done && (m_rows == N);
            e_rdy    = g && (in_load || in_drain);
            e_wen    = (in_load && e_rdy && bus.load_tensor_row_wvalid) || (in_fill && g);
            e_data   = in_load ? bus.load_tensor_row_wdata : '0;
            chk("busy", tensor_row_t'(busy), tensor_row_t'(m_busy));
            chk("loadreg_wready", tensor_row_t'(bus.loadreg_wready), tensor_row_t'(!m_busy));
            chk("row_wready", tensor_row_t'(bus.load_tensor_row_wready), tensor_row_t'(e_rdy));
            chk("wenable", tensor_row_t'(bus.mreg_move_wenable), tensor_row_t'(e_wen));
            chk("wdata", bus.mreg_move_wdata_list1d, e_data);
`ifdef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
            chk("overflow", tensor_row_t'(overflow), tensor_row_t'(m_ovf));
`endif
            if (bus.mreg_move_wenable) got_q.push_back(bus.mreg_move_wdata_list1d);
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic request();
        bus.loadreg_wrequest = 1'b1;
        cyc();
        bus.loadreg_wrequest = 1'b0;
    endtask

    task automatic send_row(input tensor_row_t data, input bit last);
        bit done;
        done = 0;
        bus.load_tensor_row_wvalid = 1'b1;
        bus.load_tensor_row_wdata  = data;
        bus.load_tensor_row_wlast  = last;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            done = bus.load_tensor_row_wready;
            cyc();
        end
        if (!done) chk("send_row_timeout", tensor_row_t'(0), tensor_row_t'(1));
        bus.load_tensor_row_wvalid = 1'b0;
        bus.load_tensor_row_wlast  = 1'b0;
        bus.load_tensor_row_wdata  = '0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 0;
        for (int t = 0; t < 50 && !idle; t++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) chk("wait_idle_timeout", tensor_row_t'(0), tensor_row_t'(1));
        cyc();
    endtask

    task automatic check_writes(input string name);
        chk({name, "_count"}, tensor_row_t'(got_q.size()), tensor_row_t'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_row"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"}, tensor_row_t'(busy), '0);
        chk({name, "_ldready"}, tensor_row_t'(bus.loadreg_wready), tensor_row_t'(1));
        chk({name, "_wen"}, tensor_row_t'(bus.mreg_move_wenable), '0);
        chk({name, "_rdy"}, tensor_row_t'(bus.load_tensor_row_wready), '0);
        chk({name, "_wdata"}, bus.mreg_move_wdata_list1d, '0);
        chk({name, "_ovf"}, tensor_row_t'(overflow), '0);
        chk({name, "_state"}, tensor_row_t'(dbg.state), tensor_row_t'(2'd0));
        chk({name, "_row"}, tensor_row_t'(dbg.row), tensor_row_t'(4'b0001));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b1;
        bus.loadreg_wrequest       = 1'b0;
        bus.load_tensor_row_wvalid = 1'b0;
        bus.load_tensor_row_wlast  = 1'b0;
        bus.load_tensor_row_wdata  = '0;
        gap(2);
        rst = 1'b0;
        chk_en = 1;
        check_reset_outputs("reset");

        // exact fit
        request();
        chk("ldready_after_req", tensor_row_t'(bus.loadreg_wready), '0);
        chk("rdy_after_req", tensor_row_t'(bus.load_tensor_row_wready), tensor_row_t'(1));
        send_row('h11, 0); send_row('h22, 0); send_row('h33, 0); send_row('h44, 1);
        chk("exact_busy_fell", tensor_row_t'(busy), '0);
        exp_q = '{'h11, 'h22, 'h33, 'h44};
        check_writes("exact");
        chk("exact_ovf", tensor_row_t'(overflow), '0);

        // short stream, zero padded
        request();
        send_row('h55, 0); send_row('h66, 1);
        chk("fill_state", tensor_row_t'(dbg.state), tensor_row_t'(2'd2));
        chk("fill_wen", tensor_row_t'(bus.mreg_move_wenable), tensor_row_t'(1));
        chk("fill_rdy", tensor_row_t'(bus.load_tensor_row_wready), '0);
        chk("fill_wdata", bus.mreg_move_wdata_list1d, '0);
        wait_idle();
        exp_q = '{'h55, 'h66, '0, '0};
        check_writes("short");

        // long stream, drained
        request();
        send_row('hA1, 0); send_row('hA2, 0); send_row('hA3, 0);
        send_row('hA4, 0); send_row('hA5, 0); send_row('hA6, 1);
        wait_idle();
        exp_q = '{'hA1, 'hA2, 'hA3, 'hA4};
        check_writes("long");
`ifdef DCA_LOAD2MREG_OVERFLOW_CHECK_EN
        chk("long_ovf", tensor_row_t'(overflow), tensor_row_t'(1));
`endif

        // backpressure and enable stall
        request();
        send_row('hB1, 0);
        gap(2);
        bus.load_tensor_row_wvalid = 1'b1;
        bus.load_tensor_row_wdata  = 'hB2;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wen", tensor_row_t'(bus.mreg_move_wenable), '0);
            chk("stall_rdy", tensor_row_t'(bus.load_tensor_row_wready), '0);
            chk("stall_row", tensor_row_t'(dbg.row), tensor_row_t'(4'b0010));
            cyc();
        end
        enable = 1'b1;
        send_row('hB2, 0);
        gap(1);
        send_row('hB3, 0); send_row('hB4, 1);
        wait_idle();
        exp_q = '{'hB1, 'hB2, 'hB3, 'hB4};
        check_writes("stall");

        // clear mid-load
        request();
        send_row('hC1, 0); send_row('hC2, 0);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_reset_outputs("clear");
        request();
        send_row('hD1, 0); send_row('hD2, 0); send_row('hD3, 0); send_row('hD4, 1);
        chk("clear_reload_idle", tensor_row_t'(busy), '0);
        exp_q = '{'hC1, 'hC2, 'hD1, 'hD2, 'hD3, 'hD4};
        check_writes("clear");

        // rst together with a request
        rst = 1'b1;
        bus.loadreg_wrequest = 1'b1;
        cyc();
        rst = 1'b0;
        bus.loadreg_wrequest = 1'b0;
        check_reset_outputs("rst_req");
        gap(3);
        chk("rst_req_busy", tensor_row_t'(busy), '0);
        check_writes("rst_req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
